// File: rtl/snake_pkg.sv
// Shared snake game encodings: move directions and head-stepper FSM states.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

endpackage

// File: rtl/snake_head_stepper_if.sv
// Control/status bundle between the game controller and the head stepper.
interface snake_head_stepper_if #(
    parameter int unsigned X_W = 5,
    parameter int unsigned Y_W = 5
);
    logic           start;
    logic [1:0]     moveState;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic           step_valid;
    logic           running;
    logic           game_over;

    modport master (
        output start, moveState,
        input  head_x, head_y, step_valid, running, game_over
    );

    modport slave (
        input  start, moveState,
        output head_x, head_y, step_valid, running, game_over
    );
endinterface

// File: rtl/snake_head_stepper_tick_gen.sv
// Game tick divider: pulses tick on the last cycle of every TICK_DIV-cycle period.
module game_tick_gen #(
    parameter int unsigned TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = enable && !clear && (cnt == TERM);
endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: game FSM plus head coordinate datapath, one cell per game tick.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned X_W      = 5,
    parameter int unsigned Y_W      = 5,
    parameter int unsigned START_X  = 16,
    parameter int unsigned START_Y  = 12,
    parameter int unsigned TICK_DIV = 2_500_000,
    parameter bit          WRAP     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    snake_head_stepper_if.slave  bus
);
    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);

    state_t         state;
    logic [X_W-1:0] head_x_q, nx;
    logic [Y_W-1:0] head_y_q, ny;
    logic           step_q, run_q, over_q;
    logic           tick, hit;

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_RUN),
        .clear  (bus.start && state != ST_RUN),
        .tick   (tick)
    );

    // Edge tests come before the +/-1 so an out-of-range value is never formed.
    always_comb begin
        nx  = head_x_q;
        ny  = head_y_q;
        hit = 1'b0;
        case (dir_t'(bus.moveState))
            DIR_UP:
                if (head_y_q == '0) begin
                    if (WRAP) ny = Y_MAX; else hit = 1'b1;
                end else ny = head_y_q - Y_W'(1);
            DIR_DOWN:
                if (head_y_q == Y_MAX) begin
                    if (WRAP) ny = '0; else hit = 1'b1;
                end else ny = head_y_q + Y_W'(1);
            DIR_LEFT:
                if (head_x_q == '0) begin
                    if (WRAP) nx = X_MAX; else hit = 1'b1;
                end else nx = head_x_q - X_W'(1);
            default:
                if (head_x_q == X_MAX) begin
                    if (WRAP) nx = '0; else hit = 1'b1;
                end else nx = head_x_q + X_W'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            head_x_q <= X_START;
            head_y_q <= Y_START;
            step_q   <= 1'b0;
            run_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DEAD: begin
                    if (bus.start) begin
                        state    <= ST_RUN;
                        head_x_q <= X_START;
                        head_y_q <= Y_START;
                        run_q    <= 1'b1;
                        over_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (hit) begin
                            state  <= ST_DEAD;
                            run_q  <= 1'b0;
                            over_q <= 1'b1;
                        end else begin
                            head_x_q <= nx;
                            head_y_q <= ny;
                            step_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    run_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.head_x     = head_x_q;
    assign bus.head_y     = head_y_q;
    assign bus.step_valid = step_q;
    assign bus.running    = run_q;
    assign bus.game_over  = over_q;
endmodule

// File: tb/tb_snake_head_stepper.sv
// Randomized self-checking bench for snake_head_stepper (8x8 grid, TICK_DIV=4, WRAP off/on).
module tb_snake_head_stepper;
    localparam int TD = 4;
    localparam int G  = 8;
    localparam int SX = 4;
    localparam int SY = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snake_head_stepper_if #(.X_W(3), .Y_W(3)) bus0 ();
    snake_head_stepper_if #(.X_W(3), .Y_W(3)) bus1 ();

    snake_head_stepper #(.GRID_W(G), .GRID_H(G), .X_W(3), .Y_W(3), .START_X(SX), .START_Y(SY),
                         .TICK_DIV(TD), .WRAP(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    snake_head_stepper #(.GRID_W(G), .GRID_H(G), .X_W(3), .Y_W(3), .START_X(SX), .START_Y(SY),
                         .TICK_DIV(TD), .WRAP(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int tests = 0;
    int fails = 0;

    // Reference model: cycles since entering RUN; every TD-th cycle is a step.
    int m_x[2], m_y[2], m_cyc[2];
    bit m_run[2], m_dead[2], m_sv[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_x[d] = SX; m_y[d] = SY; m_cyc[d] = 0;
            m_run[d] = 0; m_dead[d] = 0; m_sv[d] = 0;
        end
    endfunction

    function automatic logic [8:0] exp_of(int d);
        logic [2:0] ex, ey;
        ex = 3'(m_x[d]);
        ey = 3'(m_y[d]);
        return {ex, ey, m_sv[d], m_run[d], m_dead[d]};
    endfunction

    function automatic logic [8:0] obs_of(int d);
        if (d == 0) return {bus0.head_x, bus0.head_y, bus0.step_valid, bus0.running, bus0.game_over};
        return {bus1.head_x, bus1.head_y, bus1.step_valid, bus1.running, bus1.game_over};
    endfunction

    function automatic bit next_is_tick(int d);
        return m_run[d] && ((m_cyc[d] + 1) % TD == 0);
    endfunction

    task automatic clock_edge();
        for (int d = 0; d < 2; d++) begin
            bit st;
            int mv, nx, ny;
            st = (d == 0) ? bus0.start : bus1.start;
            mv = (d == 0) ? int'(bus0.moveState) : int'(bus1.moveState);
            m_sv[d] = 0;
            if (!m_run[d]) begin
                if (st) begin
                    m_run[d] = 1; m_dead[d] = 0; m_x[d] = SX; m_y[d] = SY; m_cyc[d] = 0;
                end
            end else begin
                m_cyc[d]++;
                if (m_cyc[d] % TD == 0) begin
                    nx = m_x[d] + ((mv == 3) ? 1 : (mv == 2) ? -1 : 0);
                    ny = m_y[d] + ((mv == 1) ? 1 : (mv == 0) ? -1 : 0);
                    if (d == 1) begin
                        nx = (nx + G) % G;
                        ny = (ny + G) % G;
                    end
                    if (nx < 0 || nx >= G || ny < 0 || ny >= G) begin
                        m_run[d] = 0; m_dead[d] = 1;
                    end else begin
                        m_x[d] = nx; m_y[d] = ny; m_sv[d] = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] o;
        bus0.start = 0; bus0.moveState = 2'd0;
        bus1.start = 0; bus1.moveState = 2'd0;
        rst_n = 0;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            tests++;
            if (o !== {3'd4, 3'd4, 3'b000}) begin
                fails++; $display("FAIL reset_state dut%0d got %h want %h", d, o, {3'd4, 3'd4, 3'b000});
            end
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            bus0.moveState = 2'($urandom);
            clock_edge();
            o = obs_of(0);
            tests++;
            if (o !== {3'd4, 3'd4, 3'b000}) begin
                fails++; $display("FAIL idle_hold cyc%0d got %h want %h", c, o, {3'd4, 3'd4, 3'b000});
            end
        end
    endtask

    task automatic test_run_right();
        logic [8:0] o;
        int steps = 0;
        int xs[3] = '{5, 6, 7};
        bus0.moveState = 2'd3;
        bus0.start = 1;
        clock_edge();
        bus0.start = 0;
        for (int c = 0; c < 3 * TD; c++) begin
            clock_edge();
            o = obs_of(0);
            tests++;
            if (o !== exp_of(0)) begin
                fails++; $display("FAIL run_right cyc%0d got %h want %h", c, o, exp_of(0));
            end
            if (bus0.step_valid === 1'b1) begin
                tests++;
                if (steps > 2 || bus0.head_x !== 3'(xs[steps]) || bus0.head_y !== 3'd4 || (c % TD) != TD - 1) begin
                    fails++; $display("FAIL right_step%0d cyc%0d got (%0d,%0d)", steps, c, bus0.head_x, bus0.head_y);
                end
                steps++;
            end
        end
        tests++;
        if (steps != 3) begin
            fails++; $display("FAIL right_step_count got %0d want 3", steps);
        end
    endtask

    task automatic test_wall();
        logic [8:0] o;
        for (int c = 0; c < TD; c++) begin
            clock_edge();
            o = obs_of(0);
            tests++;
            if (o !== exp_of(0)) begin
                fails++; $display("FAIL wall cyc%0d got %h want %h", c, o, exp_of(0));
            end
        end
        o = obs_of(0);
        tests++;
        if (o !== {3'd7, 3'd4, 3'b001}) begin
            fails++; $display("FAIL wall_dead got %h want %h", o, {3'd7, 3'd4, 3'b001});
        end
        bus0.start = 1;
        clock_edge();
        bus0.start = 0;
        o = obs_of(0);
        tests++;
        if (o !== {3'd4, 3'd4, 3'b010}) begin
            fails++; $display("FAIL restart got %h want %h", o, {3'd4, 3'd4, 3'b010});
        end
    endtask

    task automatic test_sampling();
        logic [8:0] o;
        bit done = 0;
        for (int c = 0; c < 2 * TD && !done; c++) begin
            bus0.moveState = next_is_tick(0) ? 2'd1 : (($urandom % 2) ? 2'd0 : 2'd2);
            clock_edge();
            o = obs_of(0);
            tests++;
            if (o !== exp_of(0)) begin
                fails++; $display("FAIL sampling cyc%0d got %h want %h", c, o, exp_of(0));
            end
            if (bus0.step_valid === 1'b1) done = 1;
        end
        tests++;
        if (!done || bus0.head_x !== 3'd4 || bus0.head_y !== 3'd5) begin
            fails++; $display("FAIL sampled_down got (%0d,%0d) want (4,5)", bus0.head_x, bus0.head_y);
        end
    endtask

    task automatic test_random_walk();
        logic [8:0] o;
        for (int c = 0; c < 200; c++) begin
            bus0.moveState = 2'($urandom);
            bus0.start = ($urandom_range(0, 5) == 0);
            clock_edge();
            o = obs_of(0);
            tests++;
            if (o !== exp_of(0)) begin
                fails++; $display("FAIL random_walk cyc%0d got %h want %h", c, o, exp_of(0));
            end
        end
        bus0.start = 0;
    endtask

    task automatic test_wrap();
        logic [8:0] o;
        int dirs[15] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2};
        bus1.start = 1;
        clock_edge();
        bus1.start = 0;
        for (int s = 0; s < 15; s++) begin
            bit seen = 0;
            bus1.moveState = 2'(dirs[s]);
            for (int c = 0; c < 2 * TD && !seen; c++) begin
                clock_edge();
                o = obs_of(1);
                tests++;
                if (o !== exp_of(1)) begin
                    fails++; $display("FAIL wrap_walk s%0d got %h want %h", s, o, exp_of(1));
                end
                if (bus1.step_valid === 1'b1) seen = 1;
            end
            if (s == 4 || s == 14) begin
                tests++;
                if (!seen || bus1.head_x !== ((s == 4) ? 3'd4 : 3'd7) || bus1.head_y !== ((s == 4) ? 3'd7 : 3'd4)) begin
                    fails++; $display("FAIL wrap_edge s%0d got (%0d,%0d)", s, bus1.head_x, bus1.head_y);
                end
            end
        end
        for (int c = 0; c < 120; c++) begin
            bus1.moveState = 2'($urandom);
            bus1.start = 1'($urandom);
            clock_edge();
            o = obs_of(1);
            tests++;
            if (o !== exp_of(1) || bus1.game_over !== 1'b0) begin
                fails++; $display("FAIL wrap_random cyc%0d got %h want %h", c, o, exp_of(1));
            end
        end
        bus1.start = 0;
    endtask

    task automatic test_reset_mid();
        logic [8:0] o;
        if (!m_run[0]) begin
            bus0.start = 1;
            clock_edge();
            bus0.start = 0;
        end
        for (int c = 0; c < 3 * TD && (m_cyc[0] % TD) != 2; c++) clock_edge();
        tests++;
        if (!m_run[0] || (m_cyc[0] % TD) != 2) begin
            fails++; $display("FAIL reset_mid_setup got cyc %0d want phase 2", m_cyc[0]);
        end
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            tests++;
            if (o !== {3'd4, 3'd4, 3'b000}) begin
                fails++; $display("FAIL reset_mid_async dut%0d got %h want %h", d, o, {3'd4, 3'd4, 3'b000});
            end
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 2 * TD; c++) begin
            bus0.moveState = 2'($urandom);
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                o = obs_of(d);
                tests++;
                if (o !== {3'd4, 3'd4, 3'b000}) begin
                    fails++; $display("FAIL reset_mid_idle dut%0d cyc%0d got %h", d, c, o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_right();
        test_wall();
        test_sampling();
        test_random_walk();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
